parity_frame_receiver: RTL and testbench

//  Receive end of the 9-bit parity frame {P, A[7:0]} built by the parity generator. Accepts a bit-serial

---
 rtl/parity_frame_receiver_pkg.sv | 22 ++
 rtl/parity_frame_receiver_sat_counter.sv | 44 ++++
 rtl/parity_frame_receiver.sv | 135 +++++++++++++
 tb/tb_parity_frame_receiver.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/parity_frame_receiver_pkg.sv
// -----------------------------------------------------------------------------
// parity_frame_receiver_pkg
// Shared definitions for the parity frame receiver:
//   - state_e        : receiver FSM state encoding
//   - PAR_EVEN/ODD   : parity mode constants (value of odd_mode)
//   - DEFAULT_DATA_W : default number of data bits per frame
// -----------------------------------------------------------------------------
package parity_frame_receiver_pkg;

  localparam int DEFAULT_DATA_W = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_e;

endpackage

// File: rtl/parity_frame_receiver_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear. Clear has priority over
// increment; the count holds at all-ones instead of wrapping.
// Ports:
//   clk     : clock (posedge)
//   rst     : asynchronous active-high reset, count -> 0
//   inc_i   : add one this cycle (ignored when saturated)
//   clr_i   : synchronous clear, wins over inc_i
//   count_o : current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/parity_frame_receiver.sv
// -----------------------------------------------------------------------------
// parity_frame_receiver
// Receives a bit-serial frame START(0), A[0]..A[DATA_W-1] (LSB first), P,
// STOP(1). Deserialises the data, checks P against the parity mode latched
// at the START slot and presents the byte with parity/framing flags. Frames
// that carry either error bump a saturating error counter.
//
// Handshake: a bit-slot is consumed on every clock edge where bit_valid is 1;
// there is no backpressure. data_valid is a one-cycle pulse one clock after
// the STOP slot; data_out/parity_err/frame_err hold until the next frame ends.
//
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   bit_valid, bit_in    : serial bit-slot strobe and line value
//   odd_mode             : 0 even / 1 odd parity, sampled at START
//   clr_err              : synchronous clear of err_count (wins over +1)
//   data_out, data_valid : received data and completion pulse
//   parity_err, frame_err: flags for the last completed frame
//   err_count            : saturating count of bad frames
//   busy                 : FSM is inside a frame
//   state_dbg            : raw FSM state for observation
// -----------------------------------------------------------------------------
module parity_frame_receiver
  import parity_frame_receiver_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_valid,
  input  logic              bit_in,
  input  logic              odd_mode,
  input  logic              clr_err,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic [CNT_W-1:0]  err_count,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_e            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] shift_q;
  logic              acc_q;       // running XOR of the data bits
  logic              mode_q;      // odd_mode captured at START
  logic              par_q;       // received parity bit
  logic [DATA_W-1:0] data_out_q;
  logic              data_valid_q;
  logic              parity_err_q;
  logic              frame_err_q;

  logic              last_bit_d;
  logic              err_inc_d;

  assign last_bit_d = (idx_q == IDX_W'(DATA_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      shift_q      <= '0;
      acc_q        <= 1'b0;
      mode_q       <= PAR_EVEN;
      par_q        <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      if (bit_valid) begin
        case (state_q)
          ST_IDLE: begin
            // A high line is idle; the first low slot is START.
            if (!bit_in) begin
              state_q <= ST_DATA;
              mode_q  <= odd_mode;
              idx_q   <= '0;
              acc_q   <= 1'b0;
            end
          end
          ST_DATA: begin
            shift_q[idx_q] <= bit_in;
            acc_q          <= acc_q ^ bit_in;
            if (last_bit_d) begin
              state_q <= ST_PARITY;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
          ST_PARITY: begin
            par_q   <= bit_in;
            state_q <= ST_STOP;
          end
          ST_STOP: begin
            // Even: error if P != ^A. Odd: error if P != ~^A.
            data_out_q   <= shift_q;
            parity_err_q <= par_q ^ acc_q ^ mode_q;
            frame_err_q  <= ~bit_in;
            data_valid_q <= 1'b1;
            state_q      <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // The counter steps in the cycle data_valid is high, so err_count shows
  // the new value one clock after the pulse.
  assign err_inc_d = data_valid_q & (parity_err_q | frame_err_q);

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (err_inc_d),
    .clr_i   (clr_err),
    .count_o (err_count)
  );

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != ST_IDLE);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_parity_frame_receiver.sv
// -----------------------------------------------------------------------------
// tb_parity_frame_receiver
// Directed frames into two receivers sharing the serial line: dut_a (CNT_W=8)
// carries the main checks through an expected-frame queue; dut_b (CNT_W=2)
// is held in reset until the error-counter saturation section.
// -----------------------------------------------------------------------------
module tb_parity_frame_receiver;
  import parity_frame_receiver_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic       bit_valid, bit_in, odd_mode;
  logic       clr_err_a, clr_err_b;

  logic [7:0] data_out_a, data_out_b;
  logic       data_valid_a, data_valid_b;
  logic       parity_err_a, parity_err_b;
  logic       frame_err_a, frame_err_b;
  logic [7:0] err_count_a;
  logic [1:0] err_count_b;
  logic       busy_a, busy_b;
  logic [1:0] state_dbg_a, state_dbg_b;

  parity_frame_receiver #(.DATA_W(8), .CNT_W(8)) dut_a (
    .clk        (clk),
    .rst        (rst_a),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .odd_mode   (odd_mode),
    .clr_err    (clr_err_a),
    .data_out   (data_out_a),
    .data_valid (data_valid_a),
    .parity_err (parity_err_a),
    .frame_err  (frame_err_a),
    .err_count  (err_count_a),
    .busy       (busy_a),
    .state_dbg  (state_dbg_a)
  );

  parity_frame_receiver #(.DATA_W(8), .CNT_W(2)) dut_b (
    .clk        (clk),
    .rst        (rst_b),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .odd_mode   (odd_mode),
    .clr_err    (clr_err_b),
    .data_out   (data_out_b),
    .data_valid (data_valid_b),
    .parity_err (parity_err_b),
    .frame_err  (frame_err_b),
    .err_count  (err_count_b),
    .busy       (busy_b),
    .state_dbg  (state_dbg_b)
  );

  // ---------------- scoreboard state ----------------
  // Entry layout: {data[7:0], parity_err, frame_err}
  logic [9:0] exp_q[$];
  int         n_checks  = 0;
  int         n_fail    = 0;
  int         model_cnt = 0;
  bit         cnt_pend  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change #1 after posedge; the slot is consumed at the next posedge.
  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    @(posedge clk); #1;
    bit_valid = 1'b0;
    bit_in    = 1'b1;
  endtask

  task automatic idle(input int n);
    bit_valid = 1'b0;
    bit_in    = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] a, input logic p, input logic stop,
                            input logic mode, input bit gaps, input bit flip_mode,
                            input logic exp_perr, input logic exp_ferr);
    exp_q.push_back({a, exp_perr, exp_ferr});
    odd_mode = mode;
    send_bit(1'b0);
    // After START the mode input is inverted to prove it is not re-sampled.
    if (flip_mode) odd_mode = ~mode;
    for (int i = 0; i < 8; i++) begin
      if (gaps) idle($urandom_range(0, 3));
      send_bit(a[i]);
      if (i == 0) check("busy_in_frame", {31'd0, busy_a}, 32'd1);
    end
    if (gaps) idle($urandom_range(1, 3));
    send_bit(p);
    if (gaps) idle($urandom_range(1, 3));
    send_bit(stop);
    // One clock after the STOP slot the pulse must be up.
    check("data_valid_latency", {31'd0, data_valid_a}, 32'd1);
    odd_mode = mode;
  endtask

  // ---------------- monitor ----------------
  task automatic monitor_loop();
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (rst_a) begin
        model_cnt = 0;
        cnt_pend  = 1'b0;
      end else begin
        if (cnt_pend) begin
          check("err_count", {24'd0, err_count_a}, model_cnt);
          cnt_pend = 1'b0;
        end
        if (data_valid_a) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_data_valid: got data_out=%0h, expected no frame (t=%0t)",
                     data_out_a, $time);
          end else begin
            e = exp_q.pop_front();
            check("data_out",   {24'd0, data_out_a},   {24'd0, e[9:2]});
            check("parity_err", {31'd0, parity_err_a}, {31'd0, e[1]});
            check("frame_err",  {31'd0, frame_err_a},  {31'd0, e[0]});
            if ((e[1] | e[0]) && (model_cnt < 255)) model_cnt++;
            cnt_pend = 1'b1;
          end
        end
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    bit_valid = 1'b0; bit_in = 1'b1; odd_mode = PAR_EVEN;
    clr_err_a = 1'b0; clr_err_b = 1'b0;
    fork
      monitor_loop();
    join_none

    repeat (2) @(posedge clk);
    #1;
    check("rst_data_out",   {24'd0, data_out_a},   32'd0);
    check("rst_data_valid", {31'd0, data_valid_a}, 32'd0);
    check("rst_parity_err", {31'd0, parity_err_a}, 32'd0);
    check("rst_frame_err",  {31'd0, frame_err_a},  32'd0);
    check("rst_err_count",  {24'd0, err_count_a},  32'd0);
    check("rst_busy",       {31'd0, busy_a},       32'd0);
    check("rst_state",      {30'd0, state_dbg_a},  {30'd0, ST_IDLE});
    rst_a = 1'b0;
    idle(2);

    // Contiguous frames, back-to-back.
    send_frame(8'hA5, 1'b0, 1'b1, PAR_EVEN, 0, 0, 1'b0, 1'b0);
    send_frame(8'h01, 1'b0, 1'b1, PAR_ODD,  0, 0, 1'b0, 1'b0);
    send_frame(8'h01, 1'b1, 1'b1, PAR_ODD,  0, 0, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, PAR_EVEN, 0, 0, 1'b0, 1'b1);
    send_frame(8'h5A, 1'b1, 1'b1, PAR_ODD,  0, 0, 1'b0, 1'b0);
    idle(2);
    check("err_count_two_bad", {24'd0, err_count_a}, 32'd2);
    check("data_out_held",     {24'd0, data_out_a},  32'h5A);
    check("data_valid_single", {31'd0, data_valid_a}, 32'd0);

    // Gaps and mode flipped after START: result follows the START-slot mode.
    send_frame(8'h96, 1'b1, 1'b1, PAR_ODD,  1, 1, 1'b0, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1, PAR_EVEN, 1, 1, 1'b0, 1'b0);
    idle(3);

    // Abort mid-frame with reset after 4 data bits.
    odd_mode = PAR_EVEN;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst_a = 1'b1;
    #1;
    check("abort_data_out",   {24'd0, data_out_a},   32'd0);
    check("abort_data_valid", {31'd0, data_valid_a}, 32'd0);
    check("abort_parity_err", {31'd0, parity_err_a}, 32'd0);
    check("abort_frame_err",  {31'd0, frame_err_a},  32'd0);
    check("abort_err_count",  {24'd0, err_count_a},  32'd0);
    check("abort_busy",       {31'd0, busy_a},       32'd0);
    @(posedge clk); #1;
    rst_a = 1'b0;
    idle(3);
    send_frame(8'hFF, 1'b0, 1'b1, PAR_EVEN, 0, 0, 1'b0, 1'b0);
    idle(3);

    // Saturation on the 2-bit counter of dut_b.
    rst_b = 1'b0;
    idle(2);
    check("b_rst_err_count", {30'd0, err_count_b}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      send_frame(8'hC3, 1'b1, 1'b1, PAR_EVEN, 0, 0, 1'b1, 1'b0);
      check("b_parity_err", {31'd0, parity_err_b}, 32'd1);
      check("b_data_out",   {24'd0, data_out_b},   32'hC3);
      idle(1);
      check("b_err_count_sat", {30'd0, err_count_b}, (k + 1 > 3) ? 32'd3 : 32'(k + 1));
    end
    send_frame(8'h3C, 1'b0, 1'b0, PAR_EVEN, 0, 0, 1'b0, 1'b1);
    check("b_frame_err", {31'd0, frame_err_b}, 32'd1);
    clr_err_b = 1'b1;   // coincides with the increment cycle
    idle(1);
    clr_err_b = 1'b0;
    check("b_clr_wins", {30'd0, err_count_b}, 32'd0);
    idle(3);
    check("b_idle_busy",  {31'd0, busy_b},       32'd0);
    check("b_idle_valid", {31'd0, data_valid_b}, 32'd0);
    check("b_idle_state", {30'd0, state_dbg_b},  {30'd0, ST_IDLE});
    check("queue_empty",  exp_q.size(),          32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
